// File: rtl/vedic_mul4_seq.sv
// Iterative 4x4 unsigned Urdhva Tiryakbhyam multiplier: one product column per clock, LSB first,
// with a 2-bit running carry. Column parity comes from a NOR-built XOR/XNOR cell chain.
module vedic_mul4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic [2:0]  col_q, col_d;
  logic [1:0]  carry_q, carry_d;
  logic [6:0]  acc_q, acc_d;
  logic [7:0]  product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  pp;
  logic [2:0]  count;
  logic [1:0]  half;
  logic        parity;

  // Four-NOR XNOR cell; XOR is the same cell followed by a NOR inverter.
  function automatic logic nor_xnor(input logic x, input logic y);
    logic n1, n2, n3;
    n1 = ~(x | y);
    n2 = ~(x | n1);
    n3 = ~(y | n1);
    return ~(n2 | n3);
  endfunction

  function automatic logic nor_xor(input logic x, input logic y);
    logic xn;
    xn = nor_xnor(x, y);
    return ~(xn | xn);
  endfunction

  // Crosswise partial products for the current column.
  always_comb begin
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = int'(col_q) - i;
      if (j >= 0 && j <= 3) pp[i] = a_q[i] & b_q[j[1:0]];
    end
  end

  always_comb begin
    count  = {2'b00, pp[0]} + {2'b00, pp[1]} + {2'b00, pp[2]} + {2'b00, pp[3]};
    half   = 2'((count + {1'b0, carry_q}) >> 1);
    parity = nor_xor(nor_xor(nor_xor(pp[0], pp[1]), nor_xor(pp[2], pp[3])), carry_q[0]);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    col_d     = col_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          col_d   = '0;
          carry_d = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d[col_q] = parity;
        carry_d      = half;
        if (col_q == 3'd6) begin
          // Register the result now so it is visible throughout the DONE cycle.
          product_d = {half[0], parity, acc_q[5:0]};
          done_d    = 1'b1;
          state_d   = StDone;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      col_q     <= '0;
      carry_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      col_q     <= col_d;
      carry_q   <= carry_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vedic_mul4_seq.sv
// Directed and exhaustive self-checking bench for vedic_mul4_seq.
module tb_vedic_mul4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic [7:0] product;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] prev_prod = 8'h00;

  vedic_mul4_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at the current cycle T and advance to T+8 (DONE), checking every cycle on the way.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp,
                        input string tag);
    int ndone;
    ndone = 0;
    a     = x;
    b     = y;
    start = 1'b1;
    check({tag, " busy@T"}, 32'(busy), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      if (done) ndone++;
      check({tag, " busy"}, 32'(busy), 32'd1);
      if (k < 8) check({tag, " prod hold"}, 32'(product), 32'(prev_prod));
    end
    check({tag, " done@T+8"}, 32'(done), 32'd1);
    check({tag, " done count"}, 32'(ndone), 32'd1);
    check({tag, " product"}, 32'(product), 32'(exp));
    prev_prod = exp;
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, " busy@T+9"}, 32'(busy), 32'd0);
    check({tag, " done@T+9"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    rst = 1'b0;
    check("reset product", 32'(product), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    // start together with reset: reset wins
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd5;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst+start busy", 32'(busy), 32'd0);
    step();
    check("rst+start busy later", 32'(busy), 32'd0);

    run_op(4'd0, 4'd0, 8'h00, "zero");
    idle_check("zero");
    run_op(4'd15, 4'd15, 8'hE1, "15x15");
    idle_check("15x15");

    // Operand change and start pulse mid-run are ignored.
    ndone = 0;
    a     = 4'd9;
    b     = 4'd6;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      start = (k == 4);
      if (k == 2) begin
        a = 4'd3;
        b = 4'd3;
      end
      if (done) ndone++;
      if (k == 8) check("mid product", 32'(product), 32'h36);
      if (k == 8) check("mid done", 32'(done), 32'd1);
    end
    start = 1'b0;
    check("mid done count", 32'(ndone), 32'd1);
    check("mid busy@T+9", 32'(busy), 32'd0);
    prev_prod = 8'h36;

    // Abort by reset during RUN.
    step();
    ndone = 0;
    a     = 4'd7;
    b     = 4'd5;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      start = 1'b0;
      if (done) ndone++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (done) ndone++;
    check("abort product", 32'(product), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    prev_prod = 8'h00;
    step();
    if (done) ndone++;
    check("abort no done", 32'(ndone), 32'd0);
    run_op(4'd2, 4'd3, 8'h06, "after abort");
    idle_check("after abort");

    // Back-to-back with start held at T+8.
    run_op(4'd12, 4'd11, 8'h84, "b2b first");
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    step();
    check("b2b T+8 start ignored", 32'(busy), 32'd0);
    run_op(4'd1, 4'd1, 8'h01, "b2b second");
    idle_check("b2b second");

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(4'(x), 4'(y), 8'(x * y), "exh");
        idle_check("exh");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
